alu_bist: RTL and testbench

Built-in self-test sequencer for the CPU ALU. It drives opcode/operand vectors into the ALU, waits a configurable latency, and checks `result`/`ALUFlags` against an internal golden model. It sits beside the execute stage and takes the ALU's inputs through a bring-up mux, so the ALU can be verified on the FPGA without the pipeline running. It is the initiating end of the ALU interface: it drives the operands the ALU consumes and consumes the results the ALU produces.

---
 rtl/alu_bist.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_alu_bist.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the CPU ALU: drives LFSR operand vectors, checks results against a golden model.
// Define ALU_BIST_FLAGS_EN to also check the four ALU flags {N,Z,C,V}; otherwise only the result is compared.
module alu_bist #(
    parameter int unsigned  N       = 32,
    parameter int unsigned  NUM_VEC = 20,
    parameter int unsigned  LAT     = 0,
    parameter logic [N-1:0] SEED    = 32'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic [2:0]   opcode_o,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    input  logic [N-1:0] result_i,
    input  logic [3:0]   flags_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic [7:0]   err_count_o,
    output logic [7:0]   first_fail_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [N-1:0] C_TAPS     = N'(32'h8020_0003);
    localparam logic [7:0]   C_LAST_IDX = 8'(NUM_VEC - 1);
    localparam bit           C_HAS_WAIT = (LAT > 0);
    localparam logic [1:0]   C_LAT_LAST = 2'((LAT > 0) ? (LAT - 1) : 0);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;

    // Galois right-shift step; bit 31 of the taps keeps the map invertible, so zero is unreachable.
    function automatic logic [N-1:0] f_lfsr_step(input logic [N-1:0] s);
        if (s[0]) begin
            return (s >> 1) ^ C_TAPS;
        end else begin
            return s >> 1;
        end
    endfunction

    function automatic logic [N-1:0] f_gold_result(input logic [2:0] op,
                                                   input logic [N-1:0] a,
                                                   input logic [N-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_MOV:  return b;
            default: return '0;
        endcase
    endfunction

`ifdef ALU_BIST_FLAGS_EN
    function automatic logic [3:0] f_gold_flags(input logic [2:0] op,
                                                input logic [N-1:0] a,
                                                input logic [N-1:0] b,
                                                input logic [N-1:0] r);
        logic [N:0] sum;
        logic       c;
        logic       v;
        sum = {1'b0, a} + {1'b0, b};
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                c = sum[N];
                v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_SUB: begin
                c = (a >= b);
                v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            default: begin
                c = 1'b0;
                v = 1'b0;
            end
        endcase
        return {r[N-1], (r == '0), c, v};
    endfunction
`endif

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_load;
    logic         w_start_run;
    logic         w_check;
    logic         w_finish;
    logic         w_last;
    logic [2:0]   w_op_nxt;
    logic [1:0]   r_lat_cnt;
    logic [N-1:0] r_lfsr;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [2:0]   r_opcode;
    logic [7:0]   r_idx;
    logic [7:0]   r_err_count;
    logic [7:0]   r_first_fail;
    logic         r_busy;
    logic         r_done;
    logic         r_pass;
    logic [N-1:0] w_lfsr1;
    logic [N-1:0] w_lfsr2;
    logic [N-1:0] w_gold_res;
    logic         w_mismatch;

    assign w_lfsr1    = f_lfsr_step(r_lfsr);
    assign w_lfsr2    = f_lfsr_step(w_lfsr1);
    assign w_gold_res = f_gold_result(r_opcode, r_a, r_b);
    assign w_last     = (r_idx == C_LAST_IDX);

`ifdef ALU_BIST_FLAGS_EN
    logic [3:0] w_gold_flags;
    assign w_gold_flags = f_gold_flags(r_opcode, r_a, r_b, w_gold_res);
    assign w_mismatch   = (result_i != w_gold_res) || (flags_i != w_gold_flags);
`else
    logic w_unused_flags;
    assign w_unused_flags = ^flags_i;
    assign w_mismatch     = (result_i != w_gold_res);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes; a vector is loaded on every edge that enters DRIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start_run = 1'b0;
        w_check     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_DRIVE;
                    w_load      = 1'b1;
                    w_start_run = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (C_HAS_WAIT) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == C_LAT_LAST) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_CHECK: begin
                w_check = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = S_DRIVE;
                    w_load      = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Opcode sequence restarts at ADD for every run and cycles through five operations.
    always_comb begin
        w_op_nxt = 3'd0;
        if (w_start_run) begin
            w_op_nxt = 3'd0;
        end else if (r_opcode == 3'd4) begin
            w_op_nxt = 3'd0;
        end else begin
            w_op_nxt = r_opcode + 3'd1;
        end
    end

    // Latency counter, active only while in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt <= 2'd0;
        end else if (r_state == S_WAIT) begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
        end else begin
            r_lat_cnt <= 2'd0;
        end
    end

    // Vector generation: two LFSR steps per vector, state carried across runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr   <= SEED;
            r_a      <= '0;
            r_b      <= '0;
            r_opcode <= 3'd0;
        end else if (w_load) begin
            r_lfsr   <= w_lfsr2;
            r_a      <= r_lfsr;
            r_b      <= w_lfsr1;
            r_opcode <= w_op_nxt;
        end
    end

    // Vector index and error bookkeeping; an empty error count marks the first mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx        <= 8'd0;
            r_err_count  <= 8'd0;
            r_first_fail <= 8'hFF;
        end else if (w_start_run) begin
            r_idx        <= 8'd0;
            r_err_count  <= 8'd0;
            r_first_fail <= 8'hFF;
        end else if (w_check) begin
            if (!w_last) begin
                r_idx <= r_idx + 8'd1;
            end
            if (w_mismatch) begin
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
                if (r_err_count == 8'd0) begin
                    r_first_fail <= r_idx;
                end
            end
        end
    end

    // Run status; pass folds in the final CHECK's own comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_start_run) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end
            if (w_finish) begin
                r_pass <= (r_err_count == 8'd0) && !w_mismatch;
            end
        end
    end

    assign opcode_o     = r_opcode;
    assign a_o          = r_a;
    assign b_o          = r_b;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign err_count_o  = r_err_count;
    assign first_fail_o = r_first_fail;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: one LAT=0 instance with a switchable ALU model, one LAT=2 instance behind a 2-stage ALU.
module tb_alu_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [2:0]  op1, op2;
    logic [31:0] a1, b1, a2, b2, res1, res2;
    logic [3:0]  fl1, fl2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0]  err1, ff1, err2, ff2;

    int          mode = 0;
    logic [35:0] tmp1;
    logic [35:0] d1a = '0, d1b = '0, d2a = '0, d2b = '0;
    int          n_done1 = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] m_lfsr;
    logic [31:0] va [20];
    logic [31:0] vb [20];
    logic [2:0]  vop [20];
    int          exp_err, exp_ff;

    alu_bist #(.N(32), .NUM_VEC(20), .LAT(0), .SEED(32'h1)) u_dut (
        .clk(clk), .rst(rst), .start_i(start),
        .opcode_o(op1), .a_o(a1), .b_o(b1), .result_i(res1), .flags_i(fl1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .first_fail_o(ff1)
    );

    alu_bist #(.N(32), .NUM_VEC(20), .LAT(2), .SEED(32'h1)) u_dut_lat2 (
        .clk(clk), .rst(rst), .start_i(start),
        .opcode_o(op2), .a_o(a2), .b_o(b2), .result_i(res2), .flags_i(fl2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .err_count_o(err2), .first_fail_o(ff2)
    );

    // Reference ALU: {result, N, Z, C, V}.
    function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = b;
            default: r = 32'h0;
        endcase
        return {r, r[31], (r == 32'h0), c, v};
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    always_comb begin
        tmp1 = alu_fn(op1, a1, b1);
        res1 = tmp1[35:4];
        fl1  = tmp1[3:0];
        if (mode == 1) res1[0] = 1'b0;
        if (mode == 2 && op1 == 3'b001) fl1[1] = ~tmp1[1];
        if (mode == 3) begin
            res1 = d1b[35:4];
            fl1  = d1b[3:0];
        end
    end

    assign res2 = d2b[35:4];
    assign fl2  = d2b[3:0];

    always @(posedge clk) begin
        d1a <= alu_fn(op1, a1, b1);
        d1b <= d1a;
        d2a <= alu_fn(op2, a2, b2);
        d2b <= d2a;
        if (done1) n_done1 <= n_done1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_done"}, {31'd0, done1}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass1}, 32'd0);
        chk({tag, "_err"}, {24'd0, err1}, 32'd0);
        chk({tag, "_ff"}, {24'd0, ff1}, 32'hFF);
        chk({tag, "_op"}, {29'd0, op1}, 32'd0);
        chk({tag, "_a"}, a1, 32'd0);
        chk({tag, "_b"}, b1, 32'd0);
    endtask

    // Build the 20 expected vectors of the next run and the expected error summary for an ALU mode.
    task automatic model_run(input int md);
        logic [35:0] g;
        bit          mis;
        exp_err = 0;
        exp_ff  = 255;
        for (int k = 0; k < 20; k++) begin
            vop[k] = 3'(k % 5);
            va[k]  = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            vb[k]  = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            g      = alu_fn(vop[k], va[k], vb[k]);
            mis    = 1'b0;
            if (md == 1) mis = g[4];
`ifdef ALU_BIST_FLAGS_EN
            if (md == 2) mis = (vop[k] == 3'b001);
`endif
            if (mis) begin
                if (exp_err == 0) exp_ff = k;
                exp_err++;
            end
        end
    endtask

    // Pulse (or hold) start, then watch up to 'limit' cycles; cycle c is sampled on the falling edge after edge t+c.
    task automatic run_one(input bit check_vec, input bit hand, input bit hold, input int limit, input int abort_at,
                           output int first1, output int second1, output int first2, output int pulses1);
        int k;
        first1 = -1; second1 = -1; first2 = -1; pulses1 = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 1) chk("busy_rise", {31'd0, busy1}, 32'd1);
            if (hand && c == 1) begin
                chk("hand_v0_op", {29'd0, op1}, 32'd0);
                chk("hand_v0_a", a1, 32'h0000_0001);
                chk("hand_v0_b", b1, 32'h8020_0003);
            end
            if (hand && c == 3) begin
                chk("hand_v1_op", {29'd0, op1}, 32'd1);
                chk("hand_v1_a", a1, 32'hC030_0002);
                chk("hand_v1_b", b1, 32'h6018_0001);
            end
            if (check_vec && (c % 2 == 1) && c < 40) begin
                k = (c - 1) / 2;
                chk($sformatf("vec%0d_op", k), {29'd0, op1}, {29'd0, vop[k]});
                chk($sformatf("vec%0d_a", k), a1, va[k]);
                chk($sformatf("vec%0d_b", k), b1, vb[k]);
            end
            if (done1) begin
                pulses1++;
                if (first1 < 0) begin
                    first1 = c;
                    chk("busy_fall", {31'd0, busy1}, 32'd0);
                end else if (second1 < 0) begin
                    second1 = c;
                end
            end
            if (done2 && first2 < 0) first2 = c;
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset("abort");
                break;
            end
        end
    endtask

    initial begin
        int f1, s1, f2, np, nd;
        rst   = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        @(negedge clk) rst = 1'b1;
        m_lfsr = 32'h1;

        // Correct ALU: both instances must pass with the documented run lengths.
        model_run(0);
        run_one(1'b1, 1'b1, 1'b0, 85, 0, f1, s1, f2, np);
        chk("r1_done_cycle", f1, 41);
        chk("r1_done_pulses", np, 1);
        chk("r1_pass", {31'd0, pass1}, 32'd1);
        chk("r1_err", {24'd0, err1}, 32'd0);
        chk("r1_ff", {24'd0, ff1}, 32'hFF);
        chk("lat2_done_cycle", f2, 81);
        chk("lat2_pass", {31'd0, pass2}, 32'd1);
        chk("lat2_err", {24'd0, err2}, 32'd0);
        chk("lat2_ff", {24'd0, ff2}, 32'hFF);
        chk("lat2_busy_idle", {31'd0, busy2}, 32'd0);

        // Result bit 0 stuck low.
        mode = 1;
        model_run(1);
        run_one(1'b0, 1'b0, 1'b0, 50, 0, f1, s1, f2, np);
        chk("stuck_done_cycle", f1, 41);
        chk("stuck_pass", {31'd0, pass1}, 32'd0);
        chk("stuck_err", {24'd0, err1}, exp_err);
        chk("stuck_ff", {24'd0, ff1}, exp_ff);

        // Carry flag inverted on SUB only.
        mode = 2;
        model_run(2);
        run_one(1'b0, 1'b0, 1'b0, 50, 0, f1, s1, f2, np);
`ifdef ALU_BIST_FLAGS_EN
        chk("subc_pass", {31'd0, pass1}, 32'd0);
        chk("subc_err", {24'd0, err1}, 32'd4);
        chk("subc_ff", {24'd0, ff1}, 32'd1);
`else
        chk("subc_pass", {31'd0, pass1}, 32'd1);
        chk("subc_err", {24'd0, err1}, 32'd0);
`endif

        // Two-cycle ALU against a zero-latency checker.
        mode = 3;
        model_run(0);
        run_one(1'b0, 1'b0, 1'b0, 50, 0, f1, s1, f2, np);
        chk("latmis_err_nonzero", {31'd0, (err1 != 8'd0)}, 32'd1);
        chk("latmis_pass", {31'd0, pass1}, 32'd0);

        // start held high: back-to-back runs, one done per run, unchanged length.
        mode = 0;
        model_run(0);
        model_run(0);
        run_one(1'b0, 1'b0, 1'b1, 83, 0, f1, s1, f2, np);
        start = 1'b0;
        chk("hold_first_done", f1, 41);
        chk("hold_second_done", s1, 83);
        chk("hold_pulses", np, 2);
        chk("hold_pass", {31'd0, pass1}, 32'd1);

        // Reset during vector 7: immediate abort, no done, next run restarts from the seed.
        model_run(0);
        run_one(1'b1, 1'b0, 1'b0, 15, 15, f1, s1, f2, np);
        nd = n_done1;
        repeat (5) @(negedge clk);
        chk("abort_no_done", n_done1, nd);
        check_reset("abort_hold");
        @(negedge clk) rst = 1'b1;
        m_lfsr = 32'h1;
        model_run(0);
        run_one(1'b1, 1'b1, 1'b0, 45, 0, f1, s1, f2, np);
        chk("rerun_done_cycle", f1, 41);
        chk("rerun_pass", {31'd0, pass1}, 32'd1);
        chk("rerun_err", {24'd0, err1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
